// File: rtl/mips_pkg.sv
// Shared datapath widths and the writeback queue entry layout.
package mips_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular writeback queue: two pushes (push0 older) and one pop per cycle,
// with the raw entry array exposed so the caller can search it for forwarding.
module wb_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push0,
  input  wb_entry_t             push0_entry,
  input  logic                  push1,
  input  wb_entry_t             push1_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CW-1:0]         count,
  output logic [PW-1:0]         rd_ptr,
  output wb_entry_t [DEPTH-1:0] entries
);
  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr;
  wb_entry_t             first;
  logic [1:0]            n_push;

  always_comb begin
    first  = push0 ? push0_entry : push1_entry;
    n_push = {1'b0, push0} + {1'b0, push1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

  // Storage is left unreset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push0 || push1) mem[wr_ptr] <= first;
    if (push0 && push1) mem[wr_ptr + PW'(1)] <= push1_entry;
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;
endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: queues ALU/load results, drops r0, writes one per cycle.
// Optional forwarding lookup is built when WRITEBACK_FWD_EN is defined.
module writeback_unit #(
  parameter  int DATA_W = mips_pkg::DATA_W,
  parameter  int DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [2:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [2:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              in_ready,
  output logic              RegWrite,
  output logic [2:0]        write_register,
  output logic [DATA_W-1:0] write_data,
  input  logic [2:0]        fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CW-1:0]     pending
);
  import mips_pkg::*;

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] MAX_FILL = CW'(DEPTH - 2);

  logic                  acc_mem, acc_alu, q_pop;
  wb_entry_t             mem_e, alu_e, q_head;
  logic [PW-1:0]         q_rd_ptr;
  wb_entry_t [DEPTH-1:0] q_entries;

  // Two free slots guarantee both producers can land in the same cycle.
  assign in_ready = rst_n && (pending <= MAX_FILL);
  assign acc_mem  = mem_valid && in_ready && (mem_rd != '0);
  assign acc_alu  = alu_valid && in_ready && (alu_rd != '0);
  assign mem_e    = '{rd: mem_rd, data: mem_data};
  assign alu_e    = '{rd: alu_rd, data: alu_data};
  assign q_pop    = (pending != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0      (acc_mem),
    .push0_entry(mem_e),
    .push1      (acc_alu),
    .push1_entry(alu_e),
    .pop        (q_pop),
    .head       (q_head),
    .count      (pending),
    .rd_ptr     (q_rd_ptr),
    .entries    (q_entries)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else if (q_pop) begin
      RegWrite       <= 1'b1;
      write_register <= q_head.rd;
      write_data     <= q_head.data;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

`ifdef WRITEBACK_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Output register is oldest, then queue oldest->youngest; last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (fwd_rs != '0) begin
      if (RegWrite && (write_register == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = write_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = q_rd_ptr + PW'(i);
        if ((CW'(i) < pending) && (q_entries[fwd_idx].rd == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = q_entries[fwd_idx].data;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, q_rd_ptr, q_entries};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a scoreboard of expected register writes.
module tb_writeback_unit;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0, mem_valid = 1'b0;
  logic [2:0]        alu_rd = '0, mem_rd = '0, fwd_rs = '0;
  logic [15:0]       alu_data = '0, mem_data = '0;
  logic              in_ready, RegWrite, fwd_hit;
  logic [2:0]        write_register;
  logic [15:0]       write_data, fwd_data;
  logic [CW-1:0]     pending;

  writeback_unit #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .in_ready(in_ready), .RegWrite(RegWrite),
    .write_register(write_register), .write_data(write_data),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  wb_entry_t   sb[$];
  int          mdl_pend = 0;
  bit          exp_we = 1'b0;
  logic [2:0]  last_wr = '0;
  logic [15:0] last_wd = '0;
  int          checks = 0, failures = 0;
  bit          acc;
  bit          saw_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest value still headed for the register file, from the bench's own view.
  task automatic fwd_expect(output bit hit, output logic [15:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef WRITEBACK_FWD_EN
    if (fwd_rs != 0) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (!hit && sb[i].rd == fwd_rs) begin
          hit  = 1'b1;
          data = sb[i].data;
        end
      end
      if (!hit && exp_we && last_wr == fwd_rs) begin
        hit  = 1'b1;
        data = last_wd;
      end
    end
`endif
  endtask

  // Inputs are set just after a negedge; this advances one posedge and checks at the next negedge.
  task automatic step(output bit accepted);
    bit          rdy, had, eh;
    int          n;
    wb_entry_t   e;
    logic [15:0] ed;
    rdy = rst_n && (mdl_pend <= DEPTH - 2);
    n   = 0;
    if (rdy && mem_valid && mem_rd != 0) begin
      sb.push_back(wb_entry_t'{rd: mem_rd, data: mem_data}); n++;
    end
    if (rdy && alu_valid && alu_rd != 0) begin
      sb.push_back(wb_entry_t'{rd: alu_rd, data: alu_data}); n++;
    end
    accepted = rdy;
    had = (mdl_pend != 0);
    @(posedge clk);
    if (!rst_n) begin
      mdl_pend = 0; sb.delete(); exp_we = 1'b0; last_wr = '0; last_wd = '0;
    end else begin
      exp_we = had;
      if (had) begin
        e = sb.pop_front();
        last_wr = e.rd;
        last_wd = e.data;
      end
      mdl_pend = mdl_pend + n - (had ? 1 : 0);
    end
    @(negedge clk);
    chk("regwrite", RegWrite, exp_we);
    chk("write_register", write_register, last_wr);
    chk("write_data", write_data, last_wd);
    chk("pending", pending, mdl_pend);
    chk("in_ready", in_ready, rst_n && (mdl_pend <= DEPTH - 2));
    fwd_expect(eh, ed);
    chk("fwd_hit", fwd_hit, eh);
    chk("fwd_data", fwd_data, ed);
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((mdl_pend != 0 || exp_we) && guard < 20) begin
      step(acc); guard++;
    end
    chk("drain_bound", guard < 20, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    // reset state
    step(acc); step(acc);
    rst_n = 1'b1;

    // single write, latency 2
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234; fwd_rs = 3'd3;
    step(acc);
    idle();
    step(acc);
    chk("single_wr_data", write_data, 16'h1234);
    step(acc);
    chk("single_done", RegWrite, 1'b0);

    // simultaneous producers, same rd: mem is older
    mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'h00AA;
    alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 16'h00BB; fwd_rs = 3'd2;
    step(acc);
    idle();
`ifdef WRITEBACK_FWD_EN
    chk("fwd_both_data", fwd_data, 16'h00BB);
`else
    chk("fwd_off_hit", fwd_hit, 1'b0);
`endif
    step(acc);
    chk("dual_first", write_data, 16'h00AA);
    step(acc);
    chk("dual_second", write_data, 16'h00BB);
    fwd_rs = 3'd0;
    step(acc);

    // r0 offers are dropped
    alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'hFFFF;
    step(acc);
    idle();
    step(acc);
    chk("r0_pending", pending, 0);

    // backpressure: three back-to-back pairs, producers hold while stalled
    saw_stall = 1'b0;
    fwd_rs = 3'd5;
    for (int k = 0, g = 0; k < 3 && g < 12; g++) begin
      mem_valid = 1'b1; mem_rd = 3'(k + 1); mem_data = 16'h0100 + 16'(k);
      alu_valid = 1'b1; alu_rd = 3'(k + 4); alu_data = 16'h0200 + 16'(k);
      step(acc);
      if (!in_ready) saw_stall = 1'b1;
      if (acc) k++;
    end
    idle();
    chk("bp_stall_seen", saw_stall, 1'b1);
    drain();
    chk("bp_pending_zero", pending, 0);

    // reset mid-operation with three entries queued
    fwd_rs = 3'd6;
    mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 16'hC0D0;
    alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 16'hC0D1;
    step(acc);
    mem_rd = 3'd6; mem_data = 16'hC0D2;
    alu_rd = 3'd7; alu_data = 16'hC0D3;
    step(acc);
    idle();
    chk("pre_reset_pending", pending, 3);
    rst_n = 1'b0;
    step(acc);
    rst_n = 1'b1;
    chk("post_reset_pending", pending, 0);
    for (int i = 0; i < 4; i++) step(acc);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
